// File: rtl/ex_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_unit
// Purpose  : Execute-stage ALU with registered outputs and iterative MUL.
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_unit #(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [3:0]      alu_state,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            branch_taken,
   output logic            illegal
);

   localparam int              c_CW   = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

   localparam logic [3:0] c_OP_ADD = 4'b0000;
   localparam logic [3:0] c_OP_SUB = 4'b0001;
   localparam logic [3:0] c_OP_SLL = 4'b0010;
   localparam logic [3:0] c_OP_XOR = 4'b0011;
   localparam logic [3:0] c_OP_SRL = 4'b0100;
   localparam logic [3:0] c_OP_OR  = 4'b0101;
   localparam logic [3:0] c_OP_AND = 4'b0110;
   localparam logic [3:0] c_OP_BEQ = 4'b1001;
   localparam logic [3:0] c_OP_BLT = 4'b1010;
   localparam logic [3:0] c_OP_JAL = 4'b1011;
   localparam logic [3:0] c_OP_MUL = 4'b1100;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
   logic [XLEN-1:0]   r_mcand, w_mcand_nxt;
   logic [XLEN-1:0]   r_mplier, w_mplier_nxt;
   logic [XLEN-1:0]   r_acc, w_acc_nxt;
   logic [XLEN-1:0]   r_result, w_result_nxt;
   logic              r_taken, w_taken_nxt;
   logic              r_illegal, w_illegal_nxt;
   logic              r_valid, w_valid_nxt;

   logic [XLEN-1:0]   w_alu_res;
   logic              w_alu_taken;
   logic              w_alu_ill;
   logic [c_CW-1:0]   w_sh;
   logic              w_is_mul;
   logic [XLEN-1:0]   w_acc_sum;

   assign w_sh      = op_b[c_CW-1:0];
   assign w_is_mul  = MUL_EN && (alu_state == c_OP_MUL);
   assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Single-cycle datapath; MUL is never routed here, so 1100 lands in default
   always_comb begin
      w_alu_res   = '0;
      w_alu_taken = 1'b0;
      w_alu_ill   = 1'b0;
      case (alu_state)
         c_OP_ADD: w_alu_res = op_a + op_b;
         c_OP_SUB: w_alu_res = op_a - op_b;
         c_OP_SLL: w_alu_res = op_a << w_sh;
         c_OP_XOR: w_alu_res = op_a ^ op_b;
         c_OP_SRL: w_alu_res = op_a >> w_sh;
         c_OP_OR:  w_alu_res = op_a | op_b;
         c_OP_AND: w_alu_res = op_a & op_b;
         c_OP_BEQ: w_alu_taken = (op_a == op_b);
         c_OP_BLT: w_alu_taken = ($signed(op_a) < $signed(op_b));
         c_OP_JAL: begin
            w_alu_res   = op_a + XLEN'(4);
            w_alu_taken = 1'b1;
         end
         default:  w_alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_mcand_nxt   = r_mcand;
      w_mplier_nxt  = r_mplier;
      w_acc_nxt     = r_acc;
      w_result_nxt  = r_result;
      w_taken_nxt   = r_taken;
      w_illegal_nxt = r_illegal;
      w_valid_nxt   = 1'b0;
      if (flush) begin
         // Kill everything in flight; result deliberately keeps its old value
         w_state_nxt   = S_IDLE;
         w_cnt_nxt     = '0;
         w_taken_nxt   = 1'b0;
         w_illegal_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_is_mul) begin
                     w_mcand_nxt  = op_a;
                     w_mplier_nxt = op_b;
                     w_acc_nxt    = '0;
                     w_cnt_nxt    = '0;
                     w_state_nxt  = S_MUL;
                  end else begin
                     w_result_nxt  = w_alu_res;
                     w_taken_nxt   = w_alu_taken;
                     w_illegal_nxt = w_alu_ill;
                     w_valid_nxt   = 1'b1;
                  end
               end
            end
            S_MUL: begin
               w_acc_nxt    = w_acc_sum;
               w_mcand_nxt  = r_mcand << 1;
               w_mplier_nxt = r_mplier >> 1;
               w_cnt_nxt    = r_cnt + c_CW'(1);
               if (r_cnt == c_LAST) begin
                  w_result_nxt  = w_acc_sum;
                  w_taken_nxt   = 1'b0;
                  w_illegal_nxt = 1'b0;
                  w_valid_nxt   = 1'b1;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_result  <= '0;
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_mcand   <= w_mcand_nxt;
         r_mplier  <= w_mplier_nxt;
         r_acc     <= w_acc_nxt;
         r_result  <= w_result_nxt;
         r_taken   <= w_taken_nxt;
         r_illegal <= w_illegal_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   assign busy         = (r_state == S_MUL);
   assign out_valid    = r_valid;
   assign result       = r_result;
   assign branch_taken = r_taken;
   assign illegal      = r_illegal;

endmodule
`default_nettype wire
